// File: rtl/uart2wifi_core_uart_tx.sv
// Buffered 8N1 UART transmitter for the ESP-facing link.
// Host logic queues bytes in a small FIFO; a send_buffer pulse (or AUTO_SEND)
// drains the FIFO as back-to-back frames, LSB first, on tx.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle (tx=1), waiting for a drain request and queued data
// LOAD  | one clock: pop FIFO head into the shift register
// START | start bit (tx=0) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (tx=1); then next byte or back to IDLE
module uart2wifi_core_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16,
  parameter bit AUTO_SEND   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         send_buffer,
  input  logic                         clr_ovf,
  output logic                         tx,
  output logic                         busy,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  // A divider of 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int OCC_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             drain_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             empty_w;
  logic             full_w;
  logic             push;
  logic             pop;
  logic             bit_done;
  logic             want_tx;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == OCC_FULL);
  assign push     = wr_en && !full_w;
  // LOAD is only entered with data present, so its pop never underflows.
  assign pop      = (state_q == LOAD);
  assign bit_done = (cnt_q == BIT_LAST);
  assign want_tx  = drain_q || AUTO_SEND;

  // Next occupancy and sticky overflow; a dropped write beats clr_ovf.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (wr_en && full_w) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Transmit FSM with registered tx/busy and the drain request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          // send_buffer is used directly so LOAD follows the pulse by one clock.
          if ((want_tx || (send_buffer && !AUTO_SEND)) && !empty_w) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          shift_q <= mem_q[rd_ptr_q];
          state_q <= START;
          tx_q    <= 1'b0;
          cnt_q   <= '0;
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            cnt_q <= '0;
            if (want_tx && !empty_w) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              drain_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
      // The clear above only fires with the FIFO empty, so it never collides
      // with this set.
      if (send_buffer && !empty_w && !AUTO_SEND) begin
        drain_q <= 1'b1;
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart2wifi_core_uart_tx.sv
// Self-checking bench for uart2wifi_core_uart_tx, run with an 8-clock bit period.
module tb_uart2wifi_core_uart_tx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       send_buffer = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx, busy, empty, full, overflow;
  logic [4:0] count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  vec_t       vt [20];
  logic [7:0] q_data [16];

  uart2wifi_core_uart_tx #(
    .CLK_FREQ_HZ(800),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (16),
    .AUTO_SEND  (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .send_buffer(send_buffer),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .busy       (busy),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic send_pulse();
    send_buffer = 1'b1;
    step();
    send_buffer = 1'b0;
  endtask

  // Finds (or assumes) the start bit, samples mid-bit, optionally pushes a
  // byte push_at clocks into the frame. Returns with 76 clocks elapsed since s.
  task automatic capture(input logic [7:0] exp, input string nm, input bit started,
                         input int push_at, input logic [7:0] push_byte, output int s);
    bit         seen;
    logic [7:0] got;
    seen = started;
    got = 8'h00;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (tx === 1'b0) seen = 1'b1;
    end
    s = cyc;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_start: no start bit within 300 clks", nm);
      return;
    end
    for (int i = 1; i <= 76; i++) begin
      if (i == push_at) begin
        wr_en = 1'b1;
        wr_data = push_byte;
      end
      step();
      wr_en = 1'b0;
      if (i == 4) chk({nm, "_startbit"}, int'(tx), 0);
      if (i >= 12 && i <= 68 && ((i - 12) % CPB) == 0) got = {tx, got[7:1]};
      if (i == 76) chk({nm, "_stopbit"}, int'(tx), 1);
    end
    chk({nm, "_byte"}, int'(got), int'(exp));
  endtask

  initial begin
    int s, s_prev, bad;

    for (int i = 0; i < 16; i++) begin
      q_data[i]  = 8'(i * 13 + 1);
      vt[i].wr   = 1'b1;
      vt[i].d    = q_data[i];
      vt[i].clr  = 1'b0;
      vt[i].cnt  = 5'(i + 1);
      vt[i].emp  = 1'b0;
      vt[i].ful  = (i == 15);
      vt[i].ovf  = 1'b0;
    end
    // write while full: dropped, overflow set
    vt[16] = '{wr: 1'b1, d: 8'h55, clr: 1'b0, cnt: 5'd16, emp: 1'b0, ful: 1'b1, ovf: 1'b1};
    // clear alone
    vt[17] = '{wr: 1'b0, d: 8'h00, clr: 1'b1, cnt: 5'd16, emp: 1'b0, ful: 1'b1, ovf: 1'b0};
    // clear and dropped write together: set wins
    vt[18] = '{wr: 1'b1, d: 8'h55, clr: 1'b1, cnt: 5'd16, emp: 1'b0, ful: 1'b1, ovf: 1'b1};
    // sticky
    vt[19] = '{wr: 1'b0, d: 8'h00, clr: 1'b0, cnt: 5'd16, emp: 1'b0, ful: 1'b1, ovf: 1'b1};

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    #2 rst_n = 1'b1;
    step();

    // FIFO fill / overflow vectors.
    for (int i = 0; i < 20; i++) begin
      wr_en = vt[i].wr;
      wr_data = vt[i].d;
      clr_ovf = vt[i].clr;
      step();
      wr_en = 1'b0;
      clr_ovf = 1'b0;
      chk($sformatf("vec%0d_count", i), int'(count), int'(vt[i].cnt));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].emp));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].ful));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].ovf));
      chk($sformatf("vec%0d_tx", i), int'(tx), 1);
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // Drain all 16 queued bytes; the dropped 0x55 must never appear.
    send_pulse();
    s_prev = 0;
    for (int j = 0; j < 16; j++) begin
      capture(q_data[j], $sformatf("drain%0d", j), 1'b0, 0, 8'h00, s);
      chk($sformatf("drain%0d_count", j), int'(count), 15 - j);
      if (j > 0) chk($sformatf("drain%0d_gap", j), s - s_prev, 10 * CPB + 1);
      s_prev = s;
    end
    repeat (4) step();
    chk("drain_busy_end", int'(busy), 0);
    chk("drain_empty_end", int'(empty), 1);
    bad = 0;
    repeat (200) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("drain_no_extra", bad, 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", int'(overflow), 0);

    // Single byte, exact latency and busy release.
    push(8'h77);
    send_buffer = 1'b1;
    step();
    send_buffer = 1'b0;
    chk("t1_load_tx", int'(tx), 1);
    chk("t1_load_busy", int'(busy), 1);
    step();
    chk("t1_start_latency", int'(tx), 0);
    capture(8'h77, "t1", 1'b1, 0, 8'h00, s);
    repeat (3) step();
    chk("t1_busy_in_stop", int'(busy), 1);
    step();
    chk("t1_busy_fall", int'(busy), 0);
    chk("t1_empty", int'(empty), 1);

    // Two bytes back to back.
    push(8'h86);
    push(8'hFA);
    chk("t2_count2", int'(count), 2);
    send_pulse();
    capture(8'h86, "t2a", 1'b0, 0, 8'h00, s_prev);
    chk("t2_count1", int'(count), 1);
    capture(8'hFA, "t2b", 1'b0, 0, 8'h00, s);
    chk("t2_count0", int'(count), 0);
    chk("t2_gap", s - s_prev, 10 * CPB + 1);
    repeat (4) step();
    chk("t2_busy_end", int'(busy), 0);

    // send_buffer with an empty FIFO does nothing.
    send_pulse();
    bad = 0;
    repeat (20 * CPB) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t4_idle_hold", bad, 0);

    // Byte written mid-frame joins the same drain.
    push(8'h11);
    send_pulse();
    capture(8'h11, "t6a", 1'b0, 30, 8'h22, s_prev);
    capture(8'h22, "t6b", 1'b0, 0, 8'h00, s);
    chk("t6_gap", s - s_prev, 10 * CPB + 1);
    repeat (4) step();
    chk("t6_busy_end", int'(busy), 0);

    // Asynchronous reset in the middle of data bit 3.
    push(8'hF7);
    push(8'h33);
    send_pulse();
    bad = 1;
    for (int i = 0; i < 50 && bad != 0; i++) begin
      step();
      if (tx === 1'b0) bad = 0;
    end
    chk("t5_start_seen", bad, 0);
    repeat (36) step();
    chk("t5_bit3", int'(tx), 0);
    chk("t5_count_pre", int'(count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", int'(tx), 1);
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t5_no_frame", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
